// File: rtl/divconv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : divconv_ctrl
// Purpose  : Sequencing FSM for a multiplicative (Goldschmidt-style) divide /
//            square-root datapath. Drives the multiplier operand selects,
//            the remainder-path select and the datapath register enables.
// Config   : DIVCONV_CTRL_REM_EN - when defined, a REM state follows RND and
//            computes the remainder (load_regr / sel_muxr). When undefined,
//            RND goes straight to DONE and the remainder controls tie low.
// Revision : 1.0 - initial release
// ============================================================================
module divconv_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_in,
  input  logic       p_in,
  output logic       op_type,
  output logic       P,
  output logic [2:0] sel_muxa,
  output logic [2:0] sel_muxb,
  output logic       sel_muxr,
  output logic       load_rega,
  output logic       load_regb,
  output logic       load_regc,
  output logic       load_regd,
  output logic       load_regr,
  output logic       load_regs,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    IA0  = 4'd1,
    IA1  = 4'd2,
    IA2  = 4'd3,
    ITB  = 4'd4,
    ITD  = 4'd5,
    ITA  = 4'd6,
    RND  = 4'd7,
    REM  = 4'd8,
    DONE = 4'd9
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] n_iter;
  logic [1:0] cnt_inc;

  // Single precision converges in fewer refinement steps than double.
  assign n_iter  = P ? 2'd2 : 2'd3;
  assign cnt_inc = cnt + 2'd1;

`ifndef DIVCONV_CTRL_REM_EN
  // No remainder stage in this build: the remainder controls never assert.
  assign sel_muxr  = 1'b0;
  assign load_regr = 1'b0;
`endif

  // State transitions with outputs decoded for the state being entered, so
  // every control output is a flop and lines up with its state cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      op_type   <= 1'b0;
      P         <= 1'b0;
      sel_muxa  <= 3'd0;
      sel_muxb  <= 3'd0;
      load_rega <= 1'b0;
      load_regb <= 1'b0;
      load_regc <= 1'b0;
      load_regd <= 1'b0;
      load_regs <= 1'b0;
`ifdef DIVCONV_CTRL_REM_EN
      sel_muxr  <= 1'b0;
      load_regr <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sel_muxa  <= 3'd0;
      sel_muxb  <= 3'd0;
      load_rega <= 1'b0;
      load_regb <= 1'b0;
      load_regc <= 1'b0;
      load_regd <= 1'b0;
      load_regs <= 1'b0;
`ifdef DIVCONV_CTRL_REM_EN
      sel_muxr  <= 1'b0;
      load_regr <= 1'b0;
`endif
      done      <= 1'b0;
      busy      <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            op_type   <= op_in;
            P         <= p_in;
            cnt       <= 2'd0;
            state     <= IA0;
            busy      <= 1'b1;
            sel_muxa  <= 3'd1;
            sel_muxb  <= 3'd1;
            load_regb <= 1'b1;
          end
        end
        IA0: begin
          state    <= IA1;
          sel_muxa <= 3'd2;
          if (op_type) begin
            sel_muxb  <= 3'd1;
            load_regd <= 1'b1;
          end else begin
            sel_muxb  <= 3'd0;
            load_rega <= 1'b1;
            load_regc <= 1'b1;
          end
        end
        IA1: begin
          if (op_type) begin
            state     <= IA2;
            sel_muxa  <= 3'd4;
            sel_muxb  <= 3'd0;
            load_rega <= 1'b1;
            load_regc <= 1'b1;
          end else begin
            state     <= ITB;
            sel_muxb  <= 3'd6;
            load_regb <= 1'b1;
          end
        end
        IA2: begin
          state     <= ITB;
          sel_muxb  <= 3'd6;
          load_regb <= 1'b1;
        end
        ITB: begin
          cnt <= cnt_inc;
          if (cnt_inc == n_iter) begin
            state     <= RND;
            load_regs <= 1'b1;
          end else if (op_type) begin
            state     <= ITD;
            sel_muxb  <= 3'd3;
            load_regd <= 1'b1;
          end else begin
            state     <= ITA;
            sel_muxb  <= 3'd2;
            load_rega <= 1'b1;
            load_regc <= 1'b1;
          end
        end
        ITD: begin
          state     <= ITA;
          sel_muxa  <= 3'd4;
          sel_muxb  <= 3'd2;
          load_rega <= 1'b1;
          load_regc <= 1'b1;
        end
        ITA: begin
          state     <= ITB;
          sel_muxb  <= 3'd6;
          load_regb <= 1'b1;
        end
        RND: begin
`ifdef DIVCONV_CTRL_REM_EN
          state     <= REM;
          sel_muxr  <= 1'b1;
          load_regr <= 1'b1;
`else
          state     <= DONE;
          done      <= 1'b1;
`endif
        end
`ifdef DIVCONV_CTRL_REM_EN
        REM: begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divconv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_divconv_ctrl
// Purpose  : Self-checking bench for divconv_ctrl. Per-cycle expected control
//            vectors are listed as state-letter strings, expanded into a
//            vector table and compared cycle by cycle, followed by latency
//            measurements. Honours DIVCONV_CTRL_REM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divconv_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, op_in, p_in;
  logic       op_type, P, sel_muxr, busy, done;
  logic [2:0] sel_muxa, sel_muxb;
  logic       load_rega, load_regb, load_regc, load_regd, load_regr, load_regs;

  int checks   = 0;
  int failures = 0;

  divconv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in), .p_in(p_in),
    .op_type(op_type), .P(P), .sel_muxa(sel_muxa), .sel_muxb(sel_muxb),
    .sel_muxr(sel_muxr), .load_rega(load_rega), .load_regb(load_regb),
    .load_regc(load_regc), .load_regd(load_regd), .load_regr(load_regr),
    .load_regs(load_regs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Output word: busy, done, muxa[3], muxb[3], muxr, loads a b c d r s
  localparam logic [14:0] O_IDLE = 15'd0;
  localparam logic [14:0] O_IA0  = {1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 6'b010000};
  localparam logic [14:0] O_IA1D = {1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 6'b101000};
  localparam logic [14:0] O_IA1S = {1'b1, 1'b0, 3'd2, 3'd1, 1'b0, 6'b000100};
  localparam logic [14:0] O_IA2  = {1'b1, 1'b0, 3'd4, 3'd0, 1'b0, 6'b101000};
  localparam logic [14:0] O_ITB  = {1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 6'b010000};
  localparam logic [14:0] O_ITD  = {1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 6'b000100};
  localparam logic [14:0] O_ITAD = {1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 6'b101000};
  localparam logic [14:0] O_ITAS = {1'b1, 1'b0, 3'd4, 3'd2, 1'b0, 6'b101000};
  localparam logic [14:0] O_RND  = {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 6'b000001};
  localparam logic [14:0] O_REM  = {1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 6'b000010};
  localparam logic [14:0] O_DONE = {1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 6'b000000};

`ifdef DIVCONV_CTRL_REM_EN
  localparam int REM_CYC = 1;
`else
  localparam int REM_CYC = 0;
`endif

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        op;
    logic        p;
    logic [14:0] exp;
    logic        eop;
    logic        ep;
    logic [3:0]  tid;
  } vec_t;

  vec_t vec[$];

  function automatic logic [14:0] exp_of(input byte c, input logic op);
    case (c)
      "0":     return O_IA0;
      "1":     return op ? O_IA1S : O_IA1D;
      "2":     return O_IA2;
      "B":     return O_ITB;
      "D":     return O_ITD;
      "A":     return op ? O_ITAS : O_ITAD;
      "S":     return O_RND;
      "R":     return O_REM;
      "F":     return O_DONE;
      default: return O_IDLE;
    endcase
  endfunction

  // Remove the REM cycle from a sequence when the build has no REM state.
  function automatic string adj(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (REM_CYC == 1 || s[i] != "R") r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  task automatic add(input logic rst, st, op, p, input logic [14:0] e,
                     input logic eop, ep, input logic [3:0] tid);
    vec_t v;
    v.rst = rst; v.st = st; v.op = op; v.p = p;
    v.exp = e; v.eop = eop; v.ep = ep; v.tid = tid;
    vec.push_back(v);
  endtask

  // First entry carries the accepting start; later entries use the "rest" inputs.
  task automatic add_seq(input string s, input logic [3:0] tid,
                         input logic opf, pf, opr, pr, str,
                         input logic eop, ep);
    for (int i = 0; i < s.len(); i++) begin
      if (i == 0) add(1'b0, 1'b1, opf, pf, exp_of(s[i], eop), eop, ep, tid);
      else        add(1'b0, str, opr, pr, exp_of(s[i], eop), eop, ep, tid);
    end
  endtask

  task automatic measure(input logic op, p, input int exp_lat, input string nm);
    int lat;
    start = 1'b1; op_in = op; p_in = p;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency_%s got=%0d exp=%0d", nm, lat, exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_%s got busy=%b done=%b exp busy=0 done=0", nm, busy, done);
    end
  endtask

  initial begin
    logic [16:0] got, exp;
    reset = 1'b1; start = 1'b0; op_in = 1'b0; p_in = 1'b0;

    // t0: reset state
    add(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 1'b1, 1'b1, O_IDLE, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 1'b0, 1'b0, 4'd0);
    // t1: divide, double
    add_seq(adj("01BABABSRF"), 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 1'b0, 1'b0, 4'd1);
    // t2: sqrt, single
    add_seq(adj("012BDABSRF"), 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, O_IDLE, 1'b1, 1'b1, 4'd2);
    // t3: start held high, divide single: exactly two operations
    add_seq(adj("01BABSRFI01BABSRFI"), 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, O_IDLE, 1'b0, 1'b1, 4'd3);
    add(1'b0, 1'b0, 1'b0, 1'b1, O_IDLE, 1'b0, 1'b1, 4'd3);
    // t4: reset during sqrt double (with start high), then a full sqrt double
    add_seq("012BD", 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, O_IDLE, 1'b0, 1'b0, 4'd4);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 1'b0, 1'b0, 4'd4);
    add_seq(adj("012BDABDABSRF"), 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 1'b1, 1'b0, 4'd4);
    // t5: op_in/p_in toggled while busy; captured values must hold
    add_seq(adj("01BABSRF"), 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 1'b0, 1'b1, 4'd5);

    for (int i = 0; i < vec.size(); i++) begin
      reset = vec[i].rst; start = vec[i].st; op_in = vec[i].op; p_in = vec[i].p;
      @(posedge clk); #1;
      got = {busy, done, sel_muxa, sel_muxb, sel_muxr, load_rega, load_regb,
             load_regc, load_regd, load_regr, load_regs, op_type, P};
      exp = {vec[i].exp, vec[i].eop, vec[i].ep};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL vec%0d test%0d got=%b exp=%b", i, vec[i].tid, got, exp);
      end
    end

    reset = 1'b0; start = 1'b0;
    measure(1'b0, 1'b0, 9 + REM_CYC, "div_double");
    measure(1'b0, 1'b1, 7 + REM_CYC, "div_single");
    measure(1'b1, 1'b0, 12 + REM_CYC, "sqrt_double");
    measure(1'b1, 1'b1, 9 + REM_CYC, "sqrt_single");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divconv_ctrl.md
DIVCONV_CTRL -- requirements
Module: divconv_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock of the block.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 start  input  1  operation request; sampled only in IDLE.
REQ-004 op_in  input  1  operation: 0 = divide, 1 = square root; captured with start.
REQ-005 p_in  input  1  precision: 0 = double, 1 = single; captured with start.
REQ-006 op_type, P  output  1 each  captured op_in and p_in, held stable until the next accepted start.
REQ-007 sel_muxa, sel_muxb  output  3 each  datapath multiplicand and multiplier selects.
REQ-008 sel_muxr  output  1  remainder-path select.
REQ-009 load_rega, load_regb, load_regc, load_regd, load_regr, load_regs  output  1 each  datapath register enables.
REQ-010 busy  output  1  high in every non-IDLE state.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 States SHALL be IDLE, IA0, IA1, IA2, ITB, ITD, ITA, RND, REM, DONE, one state per cycle.
REQ-013 IDLE with start=1 SHALL capture op_in/p_in and go to IA0 next cycle; start in any other state SHALL be ignored.
REQ-014 Iteration count SHALL be N=3 for P=0 and N=2 for P=1, counted by a 2-bit counter cleared on entry to IA0.
REQ-015 Divide path: IA0 (muxa=1, muxb=1, load_regb) -> IA1 (muxa=2, muxb=0, load_rega+load_regc) -> ITB.
REQ-016 Sqrt path: IA0 (muxa=1, muxb=1, load_regb) -> IA1 (muxa=2, muxb=1, load_regd) -> IA2 (muxa=4, muxb=0, load_rega+load_regc) -> ITB.
REQ-017 ITB SHALL drive muxa=0, muxb=6, load_regb, and increment the counter; if the counter reaches N, go to RND.
REQ-018 After ITB, a divide SHALL go to ITA; a sqrt SHALL go to ITD.
REQ-019 ITD (sqrt only) SHALL drive muxa=0, muxb=3, load_regd, then go to ITA.
REQ-020 ITA SHALL drive muxb=2 and load_rega+load_regc, with muxa=0 for divide and muxa=4 for sqrt, then return to ITB.
REQ-021 RND SHALL assert load_regs with sel_muxr=0, then go to REM.
REQ-022 REM SHALL assert sel_muxr=1 and load_regr, then go to DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, then go to IDLE; start in DONE SHALL be ignored.
REQ-024 In states that do not name an output, loads SHALL be 0, sel_muxr=0, and sel_muxa/sel_muxb=0.
REQ-025 At most one of load_regb, load_regd, load_rega, load_regr, load_regs SHALL be high per cycle; load_regc is high only together with load_rega.
REQ-026 Latency from the start-accept edge to done (cycles): divide P=0 10, divide P=1 8, sqrt P=0 13, sqrt P=1 10.

Reset
REQ-027 reset=1 SHALL force IDLE, clear the counter, and drive all loads, sel_muxr, busy and done to 0, sel_muxa/sel_muxb to 0, and op_type/P to 0 on the next edge.
REQ-028 Reset SHALL take priority over start and abort any operation in progress; no load SHALL fire in the cycle after reset is sampled.

Configuration
REQ-029 Macro DIVCONV_CTRL_REM_EN: when defined, the REM state exists as in REQ-022.
REQ-030 When DIVCONV_CTRL_REM_EN is not defined, RND SHALL go directly to DONE, load_regr and sel_muxr SHALL be constant 0, and every REQ-026 latency SHALL drop by 1.

Verification
REQ-031 Divide, P=0, start pulse -> loads regb,ac,b,ac,b,ac,b,s,r in cycles 1-9; done in cycle 10 only; busy high in cycles 1-10.
REQ-032 Sqrt, P=1 -> state sequence IA0 IA1 IA2 ITB ITD ITA ITB RND REM DONE; load_regd in cycles 2 and 5; done in cycle 10.
REQ-033 Start held high for 20 cycles (divide, P=1) -> exactly two operations, done in cycles 8 and 17, with the second start accepted from IDLE in cycle 9.
REQ-034 Reset asserted in cycle 5 of sqrt P=0 -> busy=0 and all loads 0 from cycle 6; a new start then gives nominal latency.
REQ-035 Build without DIVCONV_CTRL_REM_EN, divide P=0 -> done in cycle 9; load_regr and sel_muxr never 1.
REQ-036 Change op_in/p_in while busy -> op_type/P unchanged until the next accepted start.
